// File: rtl/phy_tx_lane_sched.sv
// Transmit lane scheduler: brings the link up with a COM burst, inserts a periodic COM,
// and round-robins four lanes onto one symbol slot. Optional stats: PHY_TX_SCHED_STATS_EN.
module phy_tx_lane_sched #(
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDLE_SYM   = 8'h7C,
  parameter int         COM_PERIOD = 16,
  parameter int         INIT_COM   = 4
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic       active,
  input  logic [3:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  output logic [3:0] grant,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_k,
  output logic [1:0] state
`ifdef PHY_TX_SCHED_STATS_EN
  ,
  output logic [15:0] idle_cnt
`endif
);

  localparam int CW = (COM_PERIOD > 1) ? $clog2(COM_PERIOD) : 1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      init_cnt_q, init_cnt_d;
  logic [CW-1:0]   com_cnt_q, com_cnt_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_k_q, out_k_d;

  logic [7:0]      lane_data [4];
  logic [1:0]      cand_idx [4];
  logic [3:0]      cand_req;
  logic [1:0]      sel;
  logic            com_slot;

  assign lane_data[0] = data0;
  assign lane_data[1] = data1;
  assign lane_data[2] = data2;
  assign lane_data[3] = data3;

  // Candidate k is the lane k positions after the round-robin pointer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = ptr_q + 2'(gi);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    sel = cand_idx[3];
    for (int k = 3; k >= 0; k--) begin
      if (cand_req[k]) sel = cand_idx[k];
    end
  end

  assign com_slot = (com_cnt_q == CW'(COM_PERIOD - 1));

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    com_cnt_d   = com_cnt_q;
    ptr_d       = ptr_q;
    grant       = 4'b0000;
    out_data_d  = IDLE_SYM;
    out_valid_d = 1'b0;
    out_k_d     = 1'b1;
    if (!active) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          state_d    = ST_INIT;
          init_cnt_d = 8'd0;
        end
        ST_INIT: begin
          out_data_d = COM_SYM;
          init_cnt_d = init_cnt_q + 8'd1;
          if (init_cnt_q == 8'(INIT_COM - 1)) begin
            state_d   = ST_ACTIVE;
            com_cnt_d = '0;
          end
        end
        ST_ACTIVE: begin
          if (com_slot) begin
            out_data_d = COM_SYM;
            com_cnt_d  = '0;
          end else if (|req) begin
            grant[sel]  = 1'b1;
            out_data_d  = lane_data[sel];
            out_valid_d = 1'b1;
            out_k_d     = 1'b0;
            ptr_d       = sel + 2'd1;
            com_cnt_d   = com_cnt_q + CW'(1);
          end else begin
            com_cnt_d = com_cnt_q + CW'(1);
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WAIT;
      init_cnt_q  <= 8'd0;
      com_cnt_q   <= '0;
      ptr_q       <= 2'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_k_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      com_cnt_q   <= com_cnt_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_k_q     <= out_k_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_k     = out_k_q;
  assign state     = state_q;

`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] idle_cnt_q;
  logic        idle_emit;

  // Any IDLE leaving ACTIVE counts, including the one sent as active drops.
  assign idle_emit = (state_q == ST_ACTIVE) && (!active || (!com_slot && !(|req)));

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= 16'd0;
    end else if (state_q == ST_WAIT && active) begin
      idle_cnt_q <= 16'd0;
    end else if (idle_emit && idle_cnt_q != 16'hFFFF) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Bench for phy_tx_lane_sched: slot-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_phy_tx_lane_sched;

  localparam int P     = 16;
  localparam int NINIT = 4;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk4f = 1'b0;
  logic       reset;
  logic       active = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [7:0] data0 = 8'h10, data1 = 8'h21, data2 = 8'h32, data3 = 8'h43;
  logic [3:0] grant;
  logic [7:0] out_data;
  logic       out_valid, out_k;
  logic [1:0] state;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] idle_cnt;
`endif

  int checks = 0;
  int failures = 0;

  phy_tx_lane_sched #(.COM_SYM(COM), .IDLE_SYM(IDLE), .COM_PERIOD(P), .INIT_COM(NINIT)) dut (
    .clk4f(clk4f), .reset(reset), .active(active), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .grant(grant), .out_data(out_data), .out_valid(out_valid), .out_k(out_k),
    .state(state)
`ifdef PHY_TX_SCHED_STATS_EN
    , .idle_cnt(idle_cnt)
`endif
  );

  always #5 clk4f = ~clk4f;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, COMs sent, slots since ACTIVE entry, next lane to favour.
  int         m_state = 0;
  int         m_init = 0;
  int         m_slot = 0;
  int         m_ptr = 0;
  logic [7:0] e_data = 8'h00;
  logic       e_valid = 1'b0;
  logic       e_k = 1'b0;

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] lane_val(input int l);
    case (l)
      0: return data0;
      1: return data1;
      2: return data2;
      default: return data3;
    endcase
  endfunction

  function automatic logic [3:0] model_grant();
    int l;
    if (!active || m_state != 2 || (m_slot % P) == P - 1) return 4'b0000;
    l = pick(m_ptr, req);
    return (l < 0) ? 4'b0000 : 4'(1 << l);
  endfunction

  always @(negedge reset) begin
    m_state = 0; m_init = 0; m_slot = 0; m_ptr = 0;
    e_data = 8'h00; e_valid = 1'b0; e_k = 1'b0;
  end

  always @(posedge clk4f) begin
    int l;
    if (reset) begin
      if (!active) begin
        m_state = 0; e_data = IDLE; e_k = 1'b1; e_valid = 1'b0;
      end else if (m_state == 0) begin
        m_state = 1; m_init = 0; e_data = IDLE; e_k = 1'b1; e_valid = 1'b0;
      end else if (m_state == 1) begin
        e_data = COM; e_k = 1'b1; e_valid = 1'b0;
        m_init++;
        if (m_init == NINIT) begin m_state = 2; m_slot = 0; end
      end else begin
        if ((m_slot % P) == P - 1) begin
          e_data = COM; e_k = 1'b1; e_valid = 1'b0;
        end else begin
          l = pick(m_ptr, req);
          if (l >= 0) begin
            e_data = lane_val(l); e_k = 1'b0; e_valid = 1'b1; m_ptr = (l + 1) % 4;
          end else begin
            e_data = IDLE; e_k = 1'b1; e_valid = 1'b0;
          end
        end
        m_slot++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk4f) begin
    if (!reset) begin
      chk("rst_data", out_data, 8'h00);
      chk("rst_valid", out_valid, 0);
      chk("rst_k", out_k, 0);
      chk("rst_state", state, 0);
      chk("rst_grant", grant, 0);
    end else begin
      $display("cyc t=%0t st=%0d req=%b grant=%b out=%h v=%b k=%b",
               $time, state, req, grant, out_data, out_valid, out_k);
      chk("m_data", out_data, e_data);
      chk("m_valid", out_valid, e_valid);
      chk("m_k", out_k, e_k);
      chk("m_state", state, m_state);
      chk("m_grant", grant, model_grant());
      if ((grant & ~req) != 4'b0000) chk("grant_without_req", grant & ~req, 0);
    end
  end

  task automatic step();
    @(posedge clk4f);
    #1;
  endtask

  initial begin
    logic [7:0] lit [4];
    lit[0] = 8'h10; lit[1] = 8'h21; lit[2] = 8'h32; lit[3] = 8'h43;
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    chk("t0_rst_data", out_data, 8'h00);
    chk("t0_rst_state", state, 0);
    #10 reset = 1'b1;
    step();
    chk("wait_idle", out_data, 8'h7C);
    chk("wait_k", out_k, 1);

    // Link up: one WAIT->INIT edge, then four COMs, then ACTIVE.
    active = 1'b1;
    step();
    chk("t2_enter_init", state, 1);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("t2_init_com", out_data, 8'hBC);
      chk("t2_init_k", out_k, 1);
      chk("t2_state", state, (i == 5) ? 2 : 1);
    end
    for (int j = 0; j < 16; j++) begin
      step();
      chk("t2_active_slot", out_data, (j == 15) ? 8'hBC : 8'h7C);
    end
`ifdef PHY_TX_SCHED_STATS_EN
    chk("t2_idle_cnt", idle_cnt, 15);
`endif

    // All lanes requesting: strict rotation 0,1,2,3.
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t3_grant", grant, 1 << (i % 4));
      step();
      chk("t3_data", out_data, lit[i % 4]);
      chk("t3_valid", out_valid, 1);
    end

    // Sparse requests from ptr=0: lane1, lane3, lane1.
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_grant", grant, (i == 1) ? 4'b1000 : 4'b0010);
      step();
      chk("t4_data", out_data, (i == 1) ? 8'h43 : 8'h21);
    end

    // Idle up to the COM slot, hold a request across it.
    req = 4'b0000;
    repeat (4) step();
    req = 4'b0100;
    #1 chk("t5_com_grant", grant, 0);
    step();
    chk("t5_com_out", out_data, 8'hBC);
    chk("t5_com_k", out_k, 1);
    chk("t5_served_grant", grant, 4'b0100);
    step();
    chk("t5_served_data", out_data, 8'h32);
    chk("t5_served_valid", out_valid, 1);

    // Drop active with everything requesting, then bring the link back.
    req = 4'b1111;
    active = 1'b0;
    #1 chk("t6_gated_grant", grant, 0);
    step();
    chk("t6_drop_out", out_data, 8'h7C);
    chk("t6_drop_k", out_k, 1);
    chk("t6_drop_state", state, 0);
    active = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t6_reinit_state", state, (i == 5) ? 2 : 1);
      if (i > 1) chk("t6_reinit_com", out_data, 8'hBC);
    end
`ifdef PHY_TX_SCHED_STATS_EN
    chk("t6_idle_cnt_cleared", idle_cnt, 0);
`endif
    data0 = 8'h5A; data1 = 8'hA5;
    repeat (3) step();

    // Async reset in the middle of ACTIVE takes effect without a clock edge.
    reset = 1'b0;
    #1;
    chk("t1_async_data", out_data, 8'h00);
    chk("t1_async_k", out_k, 0);
    chk("t1_async_valid", out_valid, 0);
    chk("t1_async_state", state, 0);
    #1 reset = 1'b1;
    repeat (8) step();
    chk("t1_after_state", state, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
